sfa_out_switch_n: RTL

//  Packet-aware 1-to-N AXI4-Stream output switch with a registered output stage.

---
 rtl/sfa_out_switch_n.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/sfa_out_switch_n.sv
// Packet-aware 1-to-N AXI4-Stream output switch with a two-entry (out + skid) registered output stage.
// Destination is sampled at packet start and held until TLAST; packets with an out-of-range CONF are dropped and counted.
module sfa_out_switch_n #(
    parameter int DATA_W = 32,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2,   // 2**SEL_W must be >= N_OUT
    parameter int CNT_W  = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [SEL_W-1:0]        CONF,
    input  logic                    si_tvalid,
    output logic                    si_tready,
    input  logic [DATA_W-1:0]       si_tdata,
    input  logic                    si_tlast,
    output logic [N_OUT-1:0]        m_tvalid,
    input  logic [N_OUT-1:0]        m_tready,
    output logic [N_OUT*DATA_W-1:0] m_tdata,
    output logic [N_OUT-1:0]        m_tlast,
    output logic                    busy,
    output logic [CNT_W-1:0]        drop_cnt
);

    // Handshake: a beat moves on any interface only in a cycle where valid and
    // ready are both high at the rising edge. Valid, once raised, is not
    // withdrawn by this block until the transfer happens, and m_tvalid is a
    // pure function of registers so it never depends on m_tready.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;

    logic               out_valid_q, out_valid_d;
    logic [SEL_W-1:0]   out_port_q, out_port_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;

    logic               skid_valid_q, skid_valid_d;
    logic [SEL_W-1:0]   skid_port_q, skid_port_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic               skid_last_q, skid_last_d;

    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               accept;
    logic               conf_ok;
    logic               out_drain;
    logic               wr_en;
    logic [SEL_W-1:0]   wr_port;
    logic               drop_inc;

    // ------------------------------------------------------------------
    // Slave-side handshake
    // ------------------------------------------------------------------
    // While discarding a packet nothing is written, so backpressure from the
    // buffer is irrelevant and the slave is always drained.
    assign si_tready = ARESETN & (~skid_valid_q | (state_q == ST_DROP));
    assign accept    = si_tvalid & si_tready;
    assign conf_ok   = ({1'b0, CONF} < N_OUT_L);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (conf_ok) begin
                        sel_d = CONF;
                        if (!si_tlast) state_d = ST_PKT;
                    end else if (!si_tlast) begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PKT: begin
                if (accept && si_tlast) state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (accept && si_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (buffer write request and drop event)
    // ------------------------------------------------------------------
    always_comb begin
        wr_en    = 1'b0;
        wr_port  = sel_q;
        drop_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                wr_port  = CONF;
                wr_en    = accept & conf_ok;
                drop_inc = accept & ~conf_ok & si_tlast;
            end
            ST_PKT: begin
                wr_en = accept;
            end
            ST_DROP: begin
                drop_inc = accept & si_tlast;
            end
            default: begin
                wr_en    = 1'b0;
                drop_inc = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output stage: out entry drives the selected master port
    // ------------------------------------------------------------------
    always_comb begin
        m_tvalid = '0;
        m_tdata  = '0;
        m_tlast  = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (out_valid_q && (out_port_q == SEL_W'(i))) begin
                m_tvalid[i]                  = 1'b1;
                m_tdata[i*DATA_W +: DATA_W]  = out_data_q;
                m_tlast[i]                   = out_last_q;
            end
        end
    end

    assign out_drain = |(m_tvalid & m_tready);

    // ------------------------------------------------------------------
    // Buffer next state
    // ------------------------------------------------------------------
    // A new beat can only arrive while skid is empty (si_tready), so the
    // skid-to-out move and a buffer write never compete for the out entry.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_port_d   = out_port_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_port_d  = skid_port_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;

        if (!out_valid_q || out_drain) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_port_d   = skid_port_q;
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = wr_en;
                if (wr_en) begin
                    out_port_d = wr_port;
                    out_data_d = si_tdata;
                    out_last_d = si_tlast;
                end
            end
        end else if (wr_en) begin
            skid_valid_d = 1'b1;
            skid_port_d  = wr_port;
            skid_data_d  = si_tdata;
            skid_last_d  = si_tlast;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            out_valid_q  <= 1'b0;
            out_port_q   <= '0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_port_q  <= '0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_port_q   <= out_port_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_port_q  <= skid_port_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Drop counter (saturating) and status
    // ------------------------------------------------------------------
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_inc && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
    assign busy     = (state_q != ST_IDLE) | out_valid_q | skid_valid_q;

endmodule
